// File: rtl/bram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bram_pkg
// Description : Shared definitions for the byte-enable dual-port block RAM.
//               Read-during-write mode encodings and the lane merge helper
//               used for partial-word writes.
// Contents    : RM_WRITE_FIRST / RM_READ_FIRST / RM_NO_CHANGE
//               c_max_dw / c_max_lanes / c_lane_iw  (helper sizing)
//               lane_merge(old_word, new_word, we, lane_w)
// Revision    : 1.0  initial release
// ============================================================================
package bram_pkg;

    localparam int RM_WRITE_FIRST = 0;
    localparam int RM_READ_FIRST  = 1;
    localparam int RM_NO_CHANGE   = 2;

    // The helper works on a fixed maximum width; callers zero-extend into it
    // and slice the result back down to their own DATA_WIDTH.
    localparam int c_max_dw    = 512;
    localparam int c_max_lanes = 512;
    localparam int c_lane_iw   = 9;

    // Lanes whose enable bit is set take new_word, all others keep old_word.
    function automatic logic [c_max_dw-1:0] lane_merge(
        input logic [c_max_dw-1:0]    old_word,
        input logic [c_max_dw-1:0]    new_word,
        input logic [c_max_lanes-1:0] we,
        input int                     lane_w
    );
        logic [c_max_dw-1:0] res;
        res = old_word;
        for (int i = 0; i < c_max_dw; i++) begin
            if (we[c_lane_iw'(i / lane_w)]) begin
                res[i] = new_word[i];
            end
        end
        return res;
    endfunction

endpackage : bram_pkg
`default_nettype wire

// File: rtl/bram2_out_stage.sv
`default_nettype none
// ============================================================================
// Module      : bram2_out_stage
// Description : Per-port response path. Captures the response word and its
//               valid flag, optionally through one extra pipeline register.
//               Data holds its last value when no response is presented.
// Ports       : clk      in   clock
//               rst_n    in   asynchronous active-low reset
//               i_valid  in   a response is presented this cycle
//               i_data   in   response word
//               o_data   out  registered response word (holds when idle)
//               o_valid  out  one-cycle pulse per response
// Revision    : 1.0  initial release
// ============================================================================
module bram2_out_stage #(
    parameter int DATA_WIDTH = 64,
    parameter int PIPELINED  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid
);

    logic                  w_valid;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;

    generate
        if (PIPELINED != 0) begin : g_pipe
            logic                  r_p_valid;
            logic [DATA_WIDTH-1:0] r_p_data;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_p_valid <= 1'b0;
                    r_p_data  <= '0;
                end else begin
                    r_p_valid <= i_valid;
                    if (i_valid) begin
                        r_p_data <= i_data;
                    end
                end
            end

            assign w_valid = r_p_valid;
            assign w_data  = r_p_data;
        end else begin : g_direct
            assign w_valid = i_valid;
            assign w_data  = i_data;
        end
    endgenerate

    // Data only moves on a response so idle cycles (and NO_CHANGE writes)
    // leave the previous word visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= w_valid;
            if (w_valid) begin
                r_data <= w_data;
            end
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule : bram2_out_stage
`default_nettype wire

// File: rtl/bram2_be_pipe.sv
`default_nettype none
// ============================================================================
// Module      : bram2_be_pipe
// Description : Single-clock true dual-port RAM with per-lane byte enables,
//               selectable read-during-write mode, deterministic same-address
//               collision handling (port A wins per lane) and an optional
//               output pipeline register with per-port valid flags.
// Ports       : CLK, RST_N                  clock, async active-low reset
//               ENA, WEA, ADDRA, DIA        port A request
//               DOA, DOA_VALID              port A response
//               ENB, WEB, ADDRB, DIB        port B request
//               DOB, DOB_VALID              port B response
// Revision    : 1.0  initial release
// ============================================================================
module bram2_be_pipe
    import bram_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64,
    parameter int LANE_WIDTH = 8,
    parameter int MEMSIZE    = 1024,
    parameter int PIPELINED  = 0,
    parameter int READ_MODE  = 0
) (
    input  logic                             CLK,
    input  logic                             RST_N,
    input  logic                             ENA,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0] WEA,
    input  logic [ADDR_WIDTH-1:0]            ADDRA,
    input  logic [DATA_WIDTH-1:0]            DIA,
    output logic [DATA_WIDTH-1:0]            DOA,
    output logic                             DOA_VALID,
    input  logic                             ENB,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0] WEB,
    input  logic [ADDR_WIDTH-1:0]            ADDRB,
    input  logic [DATA_WIDTH-1:0]            DIB,
    output logic [DATA_WIDTH-1:0]            DOB,
    output logic                             DOB_VALID
);

    localparam int c_lanes = DATA_WIDTH / LANE_WIDTH;
    localparam int c_idx_w = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
    localparam logic [ADDR_WIDTH:0] c_memsize = (ADDR_WIDTH + 1)'(MEMSIZE);

    generate
        if ((LANE_WIDTH < 1) || ((DATA_WIDTH % LANE_WIDTH) != 0)) begin : g_bad_lane
            $error("bram2_be_pipe: DATA_WIDTH must be a multiple of LANE_WIDTH");
        end
        if (MEMSIZE > (2 ** ADDR_WIDTH)) begin : g_bad_size
            $error("bram2_be_pipe: MEMSIZE exceeds the address space");
        end
        if (DATA_WIDTH > c_max_dw) begin : g_bad_width
            $error("bram2_be_pipe: DATA_WIDTH exceeds lane_merge capacity");
        end
        if ((READ_MODE < 0) || (READ_MODE > 2)) begin : g_bad_mode
            $error("bram2_be_pipe: READ_MODE must be 0, 1 or 2");
        end
    endgenerate

    function automatic logic [DATA_WIDTH-1:0] f_merge(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [c_lanes-1:0]    we
    );
        logic [c_max_dw-1:0] v_res;
        v_res = lane_merge(c_max_dw'(old_w), c_max_dw'(new_w),
                           c_max_lanes'(we), LANE_WIDTH);
        return v_res[DATA_WIDTH-1:0];
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [MEMSIZE];

    logic                  w_in_a;
    logic                  w_in_b;
    logic [c_idx_w-1:0]    w_idx_a;
    logic [c_idx_w-1:0]    w_idx_b;
    logic [DATA_WIDTH-1:0] w_old_a;
    logic [DATA_WIDTH-1:0] w_old_b;
    logic                  w_is_wr_a;
    logic                  w_is_wr_b;
    logic                  w_wr_a;
    logic                  w_wr_b;
    logic                  w_same;
    logic [DATA_WIDTH-1:0] w_fin_a;
    logic [DATA_WIDTH-1:0] w_fin_b;
    logic                  w_rsp_vld_a;
    logic                  w_rsp_vld_b;
    logic [DATA_WIDTH-1:0] w_rsp_dat_a;
    logic [DATA_WIDTH-1:0] w_rsp_dat_b;

    assign w_in_a    = ({1'b0, ADDRA} < c_memsize);
    assign w_in_b    = ({1'b0, ADDRB} < c_memsize);
    assign w_idx_a   = ADDRA[c_idx_w-1:0];
    assign w_idx_b   = ADDRB[c_idx_w-1:0];
    assign w_old_a   = w_in_a ? r_mem[w_idx_a] : '0;
    assign w_old_b   = w_in_b ? r_mem[w_idx_b] : '0;
    assign w_is_wr_a = (WEA != '0);
    assign w_is_wr_b = (WEB != '0);
    // Out-of-range writes are dropped here, so they never touch the array.
    assign w_wr_a    = ENA && w_is_wr_a && w_in_a;
    assign w_wr_b    = ENB && w_is_wr_b && w_in_b;
    assign w_same    = ENA && ENB && (ADDRA == ADDRB) && w_in_a;

    // Final word at each port's address after this edge. B's lanes are merged
    // first and A's on top, so A wins wherever both enable the same lane.
    // With no write the merges degenerate to the stored (or zero) word, which
    // is exactly what a read must return, including a read that collides
    // with the other port's write.
    assign w_fin_a = f_merge(f_merge(w_old_a, DIB, (w_wr_b && w_same) ? WEB : '0),
                             DIA, w_wr_a ? WEA : '0);
    assign w_fin_b = w_same ? w_fin_a : f_merge(w_old_b, DIB, w_wr_b ? WEB : '0);

    always_ff @(posedge CLK) begin
        if (w_wr_a) begin
            r_mem[w_idx_a] <= w_fin_a;
        end
        if (w_wr_b && !(w_same && w_wr_a)) begin
            r_mem[w_idx_b] <= w_fin_b;
        end
    end

    always_comb begin
        w_rsp_vld_a = 1'b0;
        w_rsp_dat_a = w_fin_a;
        if (ENA) begin
            if (!w_is_wr_a) begin
                w_rsp_vld_a = 1'b1;
            end else begin
                case (READ_MODE)
                    RM_READ_FIRST: begin
                        w_rsp_vld_a = 1'b1;
                        w_rsp_dat_a = w_old_a;
                    end
                    RM_NO_CHANGE: begin
                        w_rsp_vld_a = 1'b0;
                    end
                    default: begin
                        w_rsp_vld_a = 1'b1;
                    end
                endcase
            end
        end
    end

    always_comb begin
        w_rsp_vld_b = 1'b0;
        w_rsp_dat_b = w_fin_b;
        if (ENB) begin
            if (!w_is_wr_b) begin
                w_rsp_vld_b = 1'b1;
            end else begin
                case (READ_MODE)
                    RM_READ_FIRST: begin
                        w_rsp_vld_b = 1'b1;
                        w_rsp_dat_b = w_old_b;
                    end
                    RM_NO_CHANGE: begin
                        w_rsp_vld_b = 1'b0;
                    end
                    default: begin
                        w_rsp_vld_b = 1'b1;
                    end
                endcase
            end
        end
    end

    bram2_out_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .PIPELINED  (PIPELINED)
    ) u_out_a (
        .clk     (CLK),
        .rst_n   (RST_N),
        .i_valid (w_rsp_vld_a),
        .i_data  (w_rsp_dat_a),
        .o_data  (DOA),
        .o_valid (DOA_VALID)
    );

    bram2_out_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .PIPELINED  (PIPELINED)
    ) u_out_b (
        .clk     (CLK),
        .rst_n   (RST_N),
        .i_valid (w_rsp_vld_b),
        .i_data  (w_rsp_dat_b),
        .o_data  (DOB),
        .o_valid (DOB_VALID)
    );

endmodule : bram2_be_pipe
`default_nettype wire

// File: tb/tb_bram2_be_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram2_be_pipe
// Description : Directed self-checking bench. Four instances cover
//               WRITE_FIRST (MEMSIZE=1000), READ_FIRST, NO_CHANGE and
//               PIPELINED=1 WRITE_FIRST.
// Revision    : 1.0  initial release
// ============================================================================
module tb_bram2_be_pipe;

    localparam int c_n = 4;

    logic        clk;
    logic        rst_n;
    logic        ena   [c_n];
    logic [7:0]  wea   [c_n];
    logic [9:0]  addra [c_n];
    logic [63:0] dia   [c_n];
    logic        enb   [c_n];
    logic [7:0]  web   [c_n];
    logic [9:0]  addrb [c_n];
    logic [63:0] dib   [c_n];
    wire  [63:0] doa   [c_n];
    wire         doa_v [c_n];
    wire  [63:0] dob   [c_n];
    wire         dob_v [c_n];

    int checks   = 0;
    int failures = 0;

    localparam logic [63:0] c_w5   = 64'h1122334455667788;
    localparam logic [63:0] c_p5   = 64'hAAAAAAAABBBBBBBB;
    localparam logic [63:0] c_m5   = 64'h11223344BBBBBBBB;
    localparam logic [63:0] c_ones = 64'hFFFFFFFFFFFFFFFF;
    localparam logic [63:0] c_col  = 64'hFFFFFFFFFFFF0201;
    localparam logic [63:0] c_x1   = 64'h0123456789ABCDEF;
    localparam logic [63:0] c_x2   = 64'hFEDCBA9876543210;
    localparam logic [63:0] c_w999 = 64'h0999099909990999;
    localparam logic [63:0] c_dead = 64'hDEADBEEFDEADBEEF;
    localparam logic [63:0] c_pb   = 64'hC0DE000000000000;

    generate
        for (genvar k = 0; k < c_n; k++) begin : g_dut
            bram2_be_pipe #(
                .ADDR_WIDTH (10),
                .DATA_WIDTH (64),
                .LANE_WIDTH (8),
                .MEMSIZE    ((k == 0) ? 1000 : 1024),
                .PIPELINED  ((k == 3) ? 1 : 0),
                .READ_MODE  ((k == 1) ? 1 : ((k == 2) ? 2 : 0))
            ) u_dut (
                .CLK       (clk),
                .RST_N     (rst_n),
                .ENA       (ena[k]),
                .WEA       (wea[k]),
                .ADDRA     (addra[k]),
                .DIA       (dia[k]),
                .DOA       (doa[k]),
                .DOA_VALID (doa_v[k]),
                .ENB       (enb[k]),
                .WEB       (web[k]),
                .ADDRB     (addrb[k]),
                .DIB       (dib[k]),
                .DOB       (dob[k]),
                .DOB_VALID (dob_v[k])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        for (int k = 0; k < c_n; k++) begin
            ena[k] = 1'b0; wea[k] = '0; addra[k] = '0; dia[k] = '0;
            enb[k] = 1'b0; web[k] = '0; addrb[k] = '0; dib[k] = '0;
        end
    endtask

    task automatic wr_a(input int k, input logic [9:0] ad, input logic [7:0] we, input logic [63:0] d);
        ena[k] = 1'b1; wea[k] = we; addra[k] = ad; dia[k] = d;
    endtask

    task automatic rd_a(input int k, input logic [9:0] ad);
        ena[k] = 1'b1; wea[k] = '0; addra[k] = ad;
    endtask

    task automatic wr_b(input int k, input logic [9:0] ad, input logic [7:0] we, input logic [63:0] d);
        enb[k] = 1'b1; web[k] = we; addrb[k] = ad; dib[k] = d;
    endtask

    task automatic rd_b(input int k, input logic [9:0] ad);
        enb[k] = 1'b1; web[k] = '0; addrb[k] = ad;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        tick();
        tick();
        chk("rst_doa0",  doa[0],   64'h0);
        chk("rst_vlda0", doa_v[0], 64'h0);
        chk("rst_dob3",  dob[3],   64'h0);
        chk("rst_vldb3", dob_v[3], 64'h0);
        rst_n = 1'b1;

        // full-word write on every instance
        for (int k = 0; k < c_n; k++) wr_a(k, 10'd5, 8'hFF, c_w5);
        tick();
        chk("wf_full_doa", doa[0],   c_w5);
        chk("wf_full_vld", doa_v[0], 64'h1);
        chk("nc_wr_vld",   doa_v[2], 64'h0);
        chk("nc_wr_hold",  doa[2],   64'h0);

        idle(); rd_b(0, 10'd5); wr_a(2, 10'd1, 8'hFF, c_x1);
        tick();
        chk("rd_b5",       dob[0],   c_w5);
        chk("rd_b5_vld",   dob_v[0], 64'h1);
        chk("idle_a_vld",  doa_v[0], 64'h0);
        chk("idle_a_hold", doa[0],   c_w5);

        // partial write, low four lanes
        idle(); wr_a(0, 10'd5, 8'h0F, c_p5); wr_a(1, 10'd5, 8'h0F, c_p5); rd_a(2, 10'd1);
        tick();
        chk("wf_part_doa", doa[0],   c_m5);
        chk("rf_part_doa", doa[1],   c_w5);
        chk("rf_part_vld", doa_v[1], 64'h1);
        chk("nc_rd_doa",   doa[2],   c_x1);
        chk("nc_rd_vld",   doa_v[2], 64'h1);

        idle(); rd_b(1, 10'd5); wr_a(2, 10'd2, 8'hFF, c_x2);
        tick();
        chk("rf_stored",   dob[1],   c_m5);
        chk("nc_wr2_hold", doa[2],   c_x1);
        chk("nc_wr2_vld",  doa_v[2], 64'h0);

        // A writes while B reads the same address
        idle(); wr_a(0, 10'd9, 8'hFF, c_ones); rd_b(0, 10'd9); rd_b(2, 10'd2);
        wr_a(1, 10'd9, 8'hFF, c_ones); rd_b(1, 10'd9);
        tick();
        chk("coll_dob",    dob[0], c_ones);
        chk("coll_doa",    doa[0], c_ones);
        chk("coll_rf_dob", dob[1], c_ones);
        chk("nc_rdb",      dob[2], c_x2);

        // both ports write the same address, lane 0 contested
        idle(); wr_a(0, 10'd9, 8'h01, 64'h1); wr_b(0, 10'd9, 8'h03, 64'h0202);
        tick();
        chk("both_doa", doa[0], c_col);
        chk("both_dob", dob[0], c_col);

        idle(); rd_a(0, 10'd9);
        tick();
        chk("both_stored", doa[0], c_col);

        // out of range with MEMSIZE=1000
        idle(); wr_a(0, 10'd999, 8'hFF, c_w999);
        tick();
        idle(); wr_a(0, 10'd1001, 8'hFF, c_dead);
        tick();
        chk("oor_wr_vld", doa_v[0], 64'h1);
        idle(); rd_a(0, 10'd1001); rd_b(0, 10'd999);
        tick();
        chk("oor_rd_doa",   doa[0],   64'h0);
        chk("oor_rd_vld",   doa_v[0], 64'h1);
        chk("oor_999_keep", dob[0],   c_w999);

        // pipelined instance: fill addr 0..3, then back-to-back reads
        for (int i = 0; i < 4; i++) begin
            idle(); wr_b(3, 10'(i), 8'hFF, c_pb + 64'(i));
            tick();
        end
        idle();
        tick();
        tick();
        rd_a(3, 10'd0);
        tick();
        chk("pipe_lat1_vld", doa_v[3], 64'h0);
        idle(); rd_a(3, 10'd1);
        tick();
        chk("pipe_d0",  doa[3],   c_pb + 64'd0);
        chk("pipe_v0",  doa_v[3], 64'h1);
        idle(); rd_a(3, 10'd2);
        tick();
        chk("pipe_d1",  doa[3],   c_pb + 64'd1);
        chk("pipe_v1",  doa_v[3], 64'h1);
        idle(); rd_a(3, 10'd3);
        tick();
        chk("pipe_d2",  doa[3],   c_pb + 64'd2);
        chk("pipe_v2",  doa_v[3], 64'h1);
        idle();
        tick();
        chk("pipe_d3",  doa[3],   c_pb + 64'd3);
        chk("pipe_v3",  doa_v[3], 64'h1);
        tick();
        chk("pipe_end_vld",  doa_v[3], 64'h0);
        chk("pipe_end_hold", doa[3],   c_pb + 64'd3);

        // reset with a request in flight
        idle(); rd_a(3, 10'd1); rd_b(0, 10'd5);
        tick();
        chk("pre_rst_dob", dob[0],   c_m5);
        chk("pre_rst_vld", dob_v[0], 64'h1);
        idle();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_dob",  dob[0],   64'h0);
        chk("rst_mid_vldb", dob_v[0], 64'h0);
        chk("rst_mid_doa3", doa[3],   64'h0);
        chk("rst_mid_vld3", doa_v[3], 64'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("no_late_vld3", doa_v[3], 64'h0);
        chk("no_late_doa3", doa[3],   64'h0);
        chk("no_late_vldb", dob_v[0], 64'h0);

        idle(); rd_b(0, 10'd5); rd_a(3, 10'd2);
        tick();
        chk("post_rst_dob",  dob[0],   c_m5);
        chk("post_rst_vldb", dob_v[0], 64'h1);
        chk("post_rst_lat3", doa_v[3], 64'h0);
        idle();
        tick();
        chk("post_rst_doa3", doa[3],   c_pb + 64'd2);
        chk("post_rst_vld3", doa_v[3], 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_bram2_be_pipe
`default_nettype wire

// File: doc/bram2_be_pipe.md
Name: bram2_be_pipe

Overview:
- Parametrised successor to the single-clock dual-port block RAM: two independent read/write ports on one clock, with per-lane byte-enable writes, selectable read-during-write mode, deterministic cross-port collision resolution and an optional output pipeline stage with per-port valid flags.
- Sits under Bluespec-generated memory wrappers and the BFS frontier/visited buffers; backs any BRAM2-style instance needing partial-word writes.

Parameters:
- ADDR_WIDTH, 10, address bus width
- DATA_WIDTH, 64, word width in bits
- LANE_WIDTH, 8, bits per byte-enable lane; DATA_WIDTH % LANE_WIDTH must be 0, else elaboration error
- MEMSIZE, 1024, number of words; must be <= 2**ADDR_WIDTH
- PIPELINED, 0, 0 = read latency 1; 1 = extra output register, latency 2
- READ_MODE, 0, 0 = WRITE_FIRST, 1 = READ_FIRST, 2 = NO_CHANGE

Ports:
- CLK  in  1  single clock for both ports
- RST_N  in  1  asynchronous active-low reset
- ENA  in  1  port A enable
- WEA  in  DATA_WIDTH/LANE_WIDTH  port A lane write enables; 0 with ENA = read
- ADDRA  in  ADDR_WIDTH  port A word address
- DIA  in  DATA_WIDTH  port A write data
- DOA  out  DATA_WIDTH  port A read data
- DOA_VALID  out  1  DOA carries the result of a request
- ENB, WEB, ADDRB, DIB, DOB, DOB_VALID  same as port A, for port B

Behaviour:
- Reset (RST_N low, async): DOA/DOB = 0, DOx_VALID = 0, pipeline stage cleared. Memory array is not reset; contents survive reset.
- Request: ENx=1 on a rising edge. Read when WEx==0; write when WEx!=0. Only lanes with WEx[i]=1 are updated.
- Latency: response on DOx/DOx_VALID exactly 1+PIPELINED cycles after the request edge. VALID is a one-cycle pulse per request; back-to-back requests give back-to-back pulses. No stall or backpressure.
- Idle cycles: DOx holds its last value; VALID is 0.
- Write-port response by READ_MODE:
  - WRITE_FIRST: merged new word (new enabled lanes, old remaining lanes); VALID=1.
  - READ_FIRST: pre-write word; VALID=1.
  - NO_CHANGE: DOx holds, VALID=0.
- Cross-port, same address, same cycle:
  - A writes, B reads: B gets the merged new word, regardless of READ_MODE.
  - B writes, A reads: symmetric.
  - Both write: per lane, A wins where both enable; otherwise each port's enabled lanes land. Each writing port's WRITE_FIRST response is the final stored word.
- Address >= MEMSIZE: write discarded, read returns 0, VALID still asserted.
- Reset mid-operation: in-flight responses dropped (no VALID after reset release); the first request after release behaves normally.
- Pipeline stage (PIPELINED=1) also resets to 0 and preserves ordering.

Decomposition:
- Shared package bram_pkg: READ_MODE constants (RM_WRITE_FIRST=0, RM_READ_FIRST=1, RM_NO_CHANGE=2) and function lane_merge(old, new, we) for the byte-enable merge.
- One sub-module bram2_out_stage, instantiated per port: holds the response register, the optional PIPELINED register and the VALID/hold logic.
- Array, collision resolution and mode selection live in bram2_be_pipe.

Test Plan:
- Reset with PIPELINED=0: write A addr 5 = 0x1122334455667788 (WEA=0xFF); read B addr 5 -> DOB = 0x1122334455667788 and DOB_VALID one cycle later; reset mid-read -> DOB = 0, VALID = 0, no late pulse.
- Partial write: addr 5 above, WEA=0x0F, DIA=0xAAAAAAAABBBBBBBB, WRITE_FIRST -> DOA = 0x11223344BBBBBBBB next cycle. Same stimulus with READ_FIRST -> DOA = 0x1122334455667788.
- Collision: A writes addr 9 = 0xFF..FF while B reads addr 9 -> DOB = 0xFF..FF. Both write addr 9, WEA=0x01 DIA=0x..01, WEB=0x03 DIB=0x..0202 -> stored 0x..0201.
- PIPELINED=1: 4 back-to-back reads of addr 0..3 -> 4 consecutive VALID pulses starting 2 cycles after the first request, data in order.
- NO_CHANGE: read addr 1 (DOA=X1), then write addr 2 -> DOA stays X1, DOA_VALID = 0 on the write's response cycle.
- Out of range, MEMSIZE=1000: write addr 1001, then read addr 1001 -> DOx = 0 with VALID=1; addr 999 unaffected.
